inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning encoded-word FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter IMEM_AW, default 10, meaning instruction-memory word-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1): field-request handshake.
REQ-006 SHALL have port req_fmt, input, 3 bits: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-007 SHALL have ports req_opcode (input, 7), req_rd/req_rs1/req_rs2 (input, 5 each), req_funct3 (input, 3), req_funct7 (input, 7) and req_imm (input, 32, byte offset or value).
REQ-008 SHALL have ports load_addr (input, 1) and start_addr (input, IMEM_AW): write-pointer load.
REQ-009 SHALL have ports imem_we (output, 1), imem_addr (output, IMEM_AW), imem_wdata (output, 32) and imem_ack (input, 1): the instruction-memory write port.
REQ-010 SHALL have ports busy (output, 1), level (output, log2(DEPTH)+1) and err (output, 1).

Function
REQ-011 Accept SHALL occur on req_valid&&req_ready; req_ready = !full (no same-cycle pass-through when full).
REQ-012 Encoding SHALL place fields per RV32I: R={f7,rs2,rs1,f3,rd,op}; I={imm[11:0],rs1,f3,rd,op}; S={imm[11:5],rs2,rs1,f3,imm[4:0],op}; B={imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U={imm[31:12],rd,op}; J={imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-013 The encoded word SHALL be registered: it enters the FIFO 1 cycle after accept, and level increments in that cycle.
REQ-014 An illegal req_fmt SHALL drop the word and pulse err high for 1 cycle, aligned with the cycle the word would have entered the FIFO.
REQ-015 The writer FSM SHALL have states IDLE and WRITE; IDLE->WRITE when the FIFO is non-empty, which drives imem_we=1 with the head word and the current pointer.
REQ-016 In WRITE, imem_we, imem_addr and imem_wdata SHALL hold stable until imem_ack; on ack the FIFO pops and the pointer increments by 1; the FSM stays in WRITE if a word remains, else goes to IDLE.
REQ-017 The pointer SHALL wrap from 2^IMEM_AW-1 to 0 silently.
REQ-018 load_addr SHALL be honoured only when busy=0; while busy=1 it SHALL be ignored and err pulsed for 1 cycle.
REQ-019 busy SHALL be 1 whenever the FIFO is non-empty, the encode stage is occupied, or the FSM is in WRITE.
REQ-020 A simultaneous FIFO push and pop SHALL leave level unchanged.

Reset
REQ-021 While rst_n=0, the block SHALL hold the FSM in IDLE, the FIFO and encode stage empty, pointer=0, imem_we=0, imem_addr=0, imem_wdata=0, level=0, busy=0, err=0 and req_ready=0.
REQ-022 req_ready SHALL rise in the first clock after rst_n deasserts.
REQ-023 Reset mid-write SHALL abandon the in-flight word and all queued words.

Configuration
REQ-024 With INST_ENC_RANGE_CHECK_EN defined, the block SHALL drop and flag (err pulse, as REQ-014) any word failing: I/S imm in signed 12-bit range; B imm in signed 13-bit range and even; J imm in signed 21-bit range and even; U imm[11:0]=0.
REQ-025 Without INST_ENC_RANGE_CHECK_EN, the block SHALL truncate out-of-range immediates per REQ-012, omit the check logic, and raise err only for REQ-014 and REQ-018.

Structure
REQ-026 The format codes, the RV32I opcode constants and the field-position constants SHALL live in shared package rv32_pkg, which the decoder also uses.
REQ-027 The FIFO SHALL be the sub-module inst_enc_fifo (parameter DEPTH; push/pop/full/empty/level); encode, range check and the writer FSM SHALL stay in the top module.

Verification
REQ-028 Scenario: I, op=0x13, rd=1, rs1=0, f3=0, imm=5, start_addr=0 -> imem_we with addr 0, wdata 0x00500093.
REQ-029 Scenario: S, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> wdata 0x0020A423; then J, op=0x6F, rd=1, imm=8 -> wdata 0x008000EF at addr+1.
REQ-030 Scenario: B, op=0x63, f3=0, rs1=rs2=0, imm=-4 -> 0xFE000EE3; U, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-031 Scenario: imem_ack held low and DEPTH+2 requests sent -> req_ready=0 once full; level=DEPTH; imem_wdata stable; all words written in order once ack resumes.
REQ-032 Scenario: start_addr=2^IMEM_AW-1 with 2 words -> written at 2^IMEM_AW-1 then 0; load_addr while busy -> err pulse and pointer unchanged.
REQ-033 Scenario: with INST_ENC_RANGE_CHECK_EN defined, I imm=2048 -> err pulse and no write; without it -> write of 0x80000093 (rd=1, rs1=0).

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I format codes, opcode constants, field positions and the
// field-packing function shared by the instruction encoder and the decoder.
package rv32_pkg;

  // Instruction format selector; codes 6 and 7 are illegal.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Base RV32I major opcodes.
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Field LSB positions inside a 32-bit instruction word.
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned F3_LSB  = 12;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned F7_LSB  = 25;

  // Raw request fields as presented on the encoder's request port.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } inst_fields_t;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return (fmt <= 3'd5);
  endfunction

  // Packs fields into an RV32I word; immediates are truncated to the
  // bits the format can carry.
  function automatic logic [31:0] encode(input inst_fields_t f);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: 7] = f.opcode;
    case (f.fmt)
      FMT_R: begin
        w[RD_LSB  +: 5] = f.rd;
        w[F3_LSB  +: 3] = f.funct3;
        w[RS1_LSB +: 5] = f.rs1;
        w[RS2_LSB +: 5] = f.rs2;
        w[F7_LSB  +: 7] = f.funct7;
      end
      FMT_I: begin
        w[RD_LSB  +: 5] = f.rd;
        w[F3_LSB  +: 3] = f.funct3;
        w[RS1_LSB +: 5] = f.rs1;
        w[31:20]        = f.imm[11:0];
      end
      FMT_S: begin
        w[F3_LSB  +: 3] = f.funct3;
        w[RS1_LSB +: 5] = f.rs1;
        w[RS2_LSB +: 5] = f.rs2;
        w[31:25]        = f.imm[11:5];
        w[11:7]         = f.imm[4:0];
      end
      FMT_B: begin
        w[F3_LSB  +: 3] = f.funct3;
        w[RS1_LSB +: 5] = f.rs1;
        w[RS2_LSB +: 5] = f.rs2;
        w[31]           = f.imm[12];
        w[30:25]        = f.imm[10:5];
        w[11:8]         = f.imm[4:1];
        w[7]            = f.imm[11];
      end
      FMT_U: begin
        w[RD_LSB +: 5] = f.rd;
        w[31:12]       = f.imm[31:12];
      end
      FMT_J: begin
        w[RD_LSB +: 5] = f.rd;
        w[31]          = f.imm[20];
        w[30:21]       = f.imm[10:1];
        w[20]          = f.imm[11];
        w[19:12]       = f.imm[19:12];
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// inst_enc_fifo: synchronous FIFO of encoded instruction words with
// occupancy count; head word is presented combinationally on rdata_o.
module inst_enc_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push, do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer advance; extra MSB distinguishes full from empty.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: accepts RV32I field requests, registers the encoded word,
// queues it and writes it to instruction memory at an auto-incrementing
// pointer. Optional immediate range checking: INST_ENC_RANGE_CHECK_EN.
module inst_encoder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IMEM_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_fmt,
  input  logic [6:0]               req_opcode,
  input  logic [4:0]               req_rd,
  input  logic [4:0]               req_rs1,
  input  logic [4:0]               req_rs2,
  input  logic [2:0]               req_funct3,
  input  logic [6:0]               req_funct7,
  input  logic [31:0]              req_imm,
  input  logic                     load_addr,
  input  logic [IMEM_AW-1:0]       start_addr,
  output logic                     imem_we,
  output logic [IMEM_AW-1:0]       imem_addr,
  output logic [31:0]              imem_wdata,
  input  logic                     imem_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wr_state_e;

  wr_state_e          state_q, state_d;
  logic               rdy_q;
  logic               stage_v_q, stage_v_d;
  logic               stage_bad_q, stage_bad_d;
  logic [31:0]        stage_word_q, stage_word_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic               err_q, err_d;

  logic               accept, bad_now, push, pop;
  logic               fifo_full, fifo_empty;
  logic [31:0]        fifo_head;
  logic [LW-1:0]      fifo_level;
  inst_fields_t       fields;

  assign fields = '{fmt: req_fmt, opcode: req_opcode, rd: req_rd,
                    rs1: req_rs1, rs2: req_rs2, funct3: req_funct3,
                    funct7: req_funct7, imm: req_imm};

`ifdef INST_ENC_RANGE_CHECK_EN
  logic range_fail;

  // Immediate must be representable by the format (and even for branches/jumps).
  always_comb begin
    range_fail = 1'b0;
    case (req_fmt)
      FMT_I, FMT_S: range_fail = !(&req_imm[31:11] || ~|req_imm[31:11]);
      FMT_B:        range_fail = !(&req_imm[31:12] || ~|req_imm[31:12]) || req_imm[0];
      FMT_J:        range_fail = !(&req_imm[31:20] || ~|req_imm[31:20]) || req_imm[0];
      FMT_U:        range_fail = |req_imm[11:0];
      default:      range_fail = 1'b0;
    endcase
  end

  assign bad_now = !fmt_legal(req_fmt) || range_fail;
`else
  assign bad_now = !fmt_legal(req_fmt);
`endif

  // The stage word counts against capacity so an accepted request always
  // has a FIFO slot waiting for it one cycle later.
  assign req_ready = rdy_q && !fifo_full &&
                     !(stage_v_q && (fifo_level == LW'(DEPTH - 1)));
  assign accept    = req_valid && req_ready;
  assign push      = stage_v_q && !stage_bad_q;

  inst_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (stage_word_q),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign imem_we    = (state_q == ST_WRITE);
  assign imem_addr  = ptr_q;
  assign imem_wdata = imem_we ? fifo_head : '0;
  assign busy       = !fifo_empty || stage_v_q || imem_we;
  assign level      = fifo_level;
  assign err        = err_q;

  // Encode stage: capture the packed word and its legality on accept.
  always_comb begin
    stage_v_d    = accept;
    stage_bad_d  = stage_bad_q;
    stage_word_d = stage_word_q;
    if (accept) begin
      stage_bad_d  = bad_now;
      stage_word_d = encode(fields);
    end
  end

  // Writer FSM: present head word until acked, pop on ack.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (imem_ack) begin
          pop = 1'b1;
          if ((fifo_level == LW'(1)) && !push) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write pointer and error pulse sources.
  always_comb begin
    ptr_d = ptr_q;
    if (load_addr && !busy) ptr_d = start_addr;
    else if (pop)           ptr_d = ptr_q + IMEM_AW'(1);
    err_d = (stage_v_q && stage_bad_q) || (load_addr && busy);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      stage_v_q    <= 1'b0;
      stage_bad_q  <= 1'b0;
      stage_word_q <= '0;
      ptr_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= 1'b1;
      stage_v_q    <= stage_v_d;
      stage_bad_q  <= stage_bad_d;
      stage_word_q <= stage_word_d;
      ptr_q        <= ptr_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed self-checking bench for inst_encoder.
module tb_inst_encoder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned IMEM_AW = 10;
  localparam int unsigned TMO     = 50;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [2:0]             req_fmt = '0;
  logic [6:0]             req_opcode = '0;
  logic [4:0]             req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]             req_funct3 = '0;
  logic [6:0]             req_funct7 = '0;
  logic [31:0]            req_imm = '0;
  logic                   load_addr = 1'b0;
  logic [IMEM_AW-1:0]     start_addr = '0;
  logic                   imem_we;
  logic [IMEM_AW-1:0]     imem_addr;
  logic [31:0]            imem_wdata;
  logic                   imem_ack = 1'b0;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;
  logic                   err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] full_words [6] = '{32'h00000093, 32'h00100113, 32'h00200193,
                                  32'h00300213, 32'h00400293, 32'h00500313};

  inst_encoder #(.DEPTH(DEPTH), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
    .req_funct7(req_funct7), .req_imm(req_imm), .load_addr(load_addr),
    .start_addr(start_addr), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_ack(imem_ack), .busy(busy),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
    req_fmt = fmt; req_opcode = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_funct3 = f3; req_funct7 = f7; req_imm = imm;
  endtask

  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge.
  task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
    req_valid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [IMEM_AW-1:0] addr,
                              input logic [31:0] data);
    for (int i = 0; i < TMO; i++) begin
      if (imem_we) break;
      @(negedge clk);
    end
    chk({tag, "_we"}, {31'b0, imem_we}, 32'd1);
    chk({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    chk({tag, "_data"}, imem_wdata, data);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_we",    {31'b0, imem_we},   32'd0);
    chk("rst_addr",  32'(imem_addr),     32'd0);
    chk("rst_wdata", imem_wdata,         32'd0);
    chk("rst_level", 32'(level),         32'd0);
    chk("rst_busy",  {31'b0, busy},      32'd0);
    chk("rst_err",   {31'b0, err},       32'd0);
    rst_n = 1'b1;
    chk("ready_pre_edge", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_post_reset", {31'b0, req_ready}, 32'd1);

    load_addr = 1'b1; start_addr = '0;
    @(negedge clk);
    load_addr = 1'b0;
    chk("load_idle_err", {31'b0, err}, 32'd0);

    // I-type addi x1,x0,5
    send("I", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("I_stage_busy", {31'b0, busy}, 32'd1);
    chk("I_stage_level", 32'(level), 32'd0);
    @(negedge clk);
    chk("I_push_level", 32'(level), 32'd1);
    chk("I_push_we", {31'b0, imem_we}, 32'd0);
    expect_write("I", 10'd0, 32'h00500093);
    chk("I_done_level", 32'(level), 32'd0);
    chk("I_done_busy", {31'b0, busy}, 32'd0);

    // S then J back to back
    send("S", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send("J", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    expect_write("S", 10'd1, 32'h0020A423);
    expect_write("J", 10'd2, 32'h008000EF);

    // B with negative offset, U, R
    send("B", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
    send("U", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    expect_write("B", 10'd3, 32'hFE000EE3);
    expect_write("U", 10'd4, 32'h123452B7);
    send("R", 3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
    expect_write("R", 10'd5, 32'h402081B3);

    // Back-pressure: ack held low, DEPTH+2 requests
    for (int k = 0; k < 4; k++)
      send("fill", 3'd1, 7'h13, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    set_req(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    req_valid = 1'b1;
    chk("full_ready_stage", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    held = imem_wdata;
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_head", held, full_words[0]);
    chk("full_head_addr", 32'(imem_addr), 32'd6);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_ready", {31'b0, req_ready}, 32'd0);
      chk("full_wdata_stable", imem_wdata, held);
      chk("full_we_held", {31'b0, imem_we}, 32'd1);
    end
    req_valid = 1'b0;
    expect_write("full0", 10'd6, full_words[0]);
    send("fill4", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    expect_write("full1", 10'd7, full_words[1]);
    send("fill5", 3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    expect_write("full2", 10'd8,  full_words[2]);
    expect_write("full3", 10'd9,  full_words[3]);
    expect_write("full4", 10'd10, full_words[4]);
    expect_write("full5", 10'd11, full_words[5]);
    chk("drain_busy", {31'b0, busy}, 32'd0);

    // Pointer wrap and load while busy
    load_addr = 1'b1; start_addr = 10'h3FF;
    @(negedge clk);
    load_addr = 1'b0;
    send("wrapA", 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send("wrapB", 3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    expect_write("wrapA", 10'h3FF, full_words[1]);
    load_addr = 1'b1; start_addr = 10'd5;
    @(negedge clk);
    load_addr = 1'b0;
    chk("busy_load_err", {31'b0, err}, 32'd1);
    @(negedge clk);
    chk("busy_load_err_clear", {31'b0, err}, 32'd0);
    expect_write("wrapB", 10'd0, full_words[2]);

    // Illegal format is dropped with an err pulse
    send("illegal", 3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("illegal_err_early", {31'b0, err}, 32'd0);
    @(negedge clk);
    chk("illegal_err", {31'b0, err}, 32'd1);
    chk("illegal_level", 32'(level), 32'd0);
    @(negedge clk);
    chk("illegal_err_clear", {31'b0, err}, 32'd0);
    chk("illegal_busy", {31'b0, busy}, 32'd0);
    chk("illegal_no_we", {31'b0, imem_we}, 32'd0);

    // Out-of-range I immediate
    send("imm2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    @(negedge clk);
`ifdef INST_ENC_RANGE_CHECK_EN
    chk("range_err", {31'b0, err}, 32'd1);
    chk("range_level", 32'(level), 32'd0);
    @(negedge clk);
    chk("range_no_we", {31'b0, imem_we}, 32'd0);
    chk("range_busy", {31'b0, busy}, 32'd0);
`else
    chk("trunc_err", {31'b0, err}, 32'd0);
    expect_write("trunc", 10'd1, 32'h80000093);
`endif

    // Reset mid-write abandons everything
    send("rstA", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    send("rstB", 3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    for (int i = 0; i < TMO; i++) begin
      if (imem_we) break;
      @(negedge clk);
    end
    chk("rst_mid_we_before", {31'b0, imem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, imem_we}, 32'd0);
    chk("rst_mid_level", 32'(level), 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_we", {31'b0, imem_we}, 32'd0);
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_addr", 32'(imem_addr), 32'd0);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
